// File: rtl/skin_segm_ctrl.sv
// Frame-level controller for the skin-colour segmentation path.
// Measures DE-delimited frame geometry, locks after a run of identical
// valid frames, gates the pipeline clock-enable on frame boundaries,
// produces pixel coordinates and double-buffers the Cb/Cr thresholds.
module skin_segm_ctrl #(
    parameter int CNT_W       = 11,
    parameter int LOCK_FRAMES = 2,
    parameter int CB_MIN_RST  = 77,
    parameter int CB_MAX_RST  = 127,
    parameter int CR_MIN_RST  = 133,
    parameter int CR_MAX_RST  = 173
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_de,
    input  logic             in_hsync,
    input  logic             in_vsync,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [7:0]       cfg_data,
    output logic [7:0]       cb_min,
    output logic [7:0]       cb_max,
    output logic [7:0]       cr_min,
    output logic [7:0]       cr_max,
    output logic             cfg_pending,
    output logic             ce,
    output logic             locked,
    output logic             frame_start,
    output logic             pix_valid,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic [CNT_W-1:0] width,
    output logic [CNT_W-1:0] height
);

    typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [2:0]       LOCK_N  = 3'(LOCK_FRAMES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    state_t           state;
    logic             vsync_q;
    logic [CNT_W-1:0] run_len, first_len, line_cnt;
    logic             frame_bad;
    logic [CNT_W-1:0] x_cnt, y_cnt;
    logic [CNT_W-1:0] cand_w, cand_h;
    logic [2:0]       match;
    logic [7:0]       shadow [4];

    // Lines are delimited by DE alone; HSYNC carries no extra information here.
    logic unused_hsync;
    assign unused_hsync = in_hsync;

    // Frame evaluation as seen on the current edge, including a run that
    // ends on this edge (DE falling, or DE still high at frame_start).
    logic             line_end, mismatch, eff_bad, frame_ok, same_geom;
    logic [CNT_W-1:0] eff_lines, eff_w;
    logic [2:0]       match_inc;

    assign line_end  = (run_len != '0) && (!in_de || frame_start);
    assign eff_lines = line_end ? sat_inc(line_cnt) : line_cnt;
    assign eff_w     = (line_cnt == '0) ? run_len : first_len;
    assign mismatch  = (line_cnt != '0) && (run_len != first_len);
    assign eff_bad   = frame_bad || (line_end && ((run_len == CNT_MAX) || mismatch))
                       || (eff_lines == CNT_MAX);
    assign frame_ok  = !eff_bad && (eff_lines != '0);
    assign same_geom = (eff_w == cand_w) && (eff_lines == cand_h);
    assign match_inc = match + 3'd1;

    // VSYNC rising-edge detector producing the registered frame_start pulse.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vsync_q     <= in_vsync;
            frame_start <= in_vsync & ~vsync_q;
        end
    end

    // Line/frame measurement: run length, first-line width, line count, bad flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_len   <= '0;
            first_len <= '0;
            line_cnt  <= '0;
            frame_bad <= 1'b0;
        end else if (frame_start) begin
            run_len   <= '0;
            first_len <= '0;
            line_cnt  <= '0;
            frame_bad <= 1'b0;
        end else if (in_de) begin
            run_len <= sat_inc(run_len);
        end else begin
            run_len <= '0;
            if (line_end) begin
                line_cnt  <= eff_lines;
                frame_bad <= eff_bad;
                if (line_cnt == '0) first_len <= run_len;
            end
        end
    end

    // Lock FSM with registered locked/ce/width/height, evaluated once per frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= SEARCH;
            match  <= '0;
            cand_w <= '0;
            cand_h <= '0;
            locked <= 1'b0;
            ce     <= 1'b0;
            width  <= '0;
            height <= '0;
        end else if (frame_start) begin
            case (state)
                SEARCH: state <= MEASURE;
                MEASURE: begin
                    if (frame_ok) begin
                        cand_w <= eff_w;
                        cand_h <= eff_lines;
                        match  <= 3'd1;
                        if (LOCK_FRAMES == 1) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                            ce     <= 1'b1;
                            width  <= eff_w;
                            height <= eff_lines;
                        end else begin
                            state <= VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    if (!frame_ok) begin
                        state <= MEASURE;
                    end else if (same_geom) begin
                        match <= match_inc;
                        if (match_inc >= LOCK_N) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                            ce     <= 1'b1;
                            width  <= eff_w;
                            height <= eff_lines;
                        end
                    end else begin
                        cand_w <= eff_w;
                        cand_h <= eff_lines;
                        match  <= 3'd1;
                    end
                end
                default: begin  // LOCKED
                    if (!(frame_ok && same_geom)) begin
                        locked <= 1'b0;
                        ce     <= 1'b0;
                        width  <= '0;
                        height <= '0;
                        if (frame_ok) begin
                            state  <= VERIFY;
                            cand_w <= eff_w;
                            cand_h <= eff_lines;
                            match  <= 3'd1;
                        end else begin
                            state <= MEASURE;
                        end
                    end
                end
            endcase
        end
    end

    // Pixel coordinates, registered alongside pix_valid (in_de delayed by one).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            x_cnt     <= '0;
            y_cnt     <= '0;
        end else begin
            pix_valid <= in_de;
            if (in_de) begin
                pix_x <= x_cnt;
                pix_y <= y_cnt;
                x_cnt <= sat_inc(x_cnt);
            end else begin
                x_cnt <= '0;
            end
            if (frame_start)              y_cnt <= '0;
            else if (pix_valid && !in_de) y_cnt <= sat_inc(y_cnt);
        end
    end

    // Shadow thresholds take writes any time; active copies update only at frame_start.
    // NOTE: the 4-entry shadow file is flops, not RAM, so it is reset like any other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow[0]   <= 8'(CB_MIN_RST);
            shadow[1]   <= 8'(CB_MAX_RST);
            shadow[2]   <= 8'(CR_MIN_RST);
            shadow[3]   <= 8'(CR_MAX_RST);
            cb_min      <= 8'(CB_MIN_RST);
            cb_max      <= 8'(CB_MAX_RST);
            cr_min      <= 8'(CR_MIN_RST);
            cr_max      <= 8'(CR_MAX_RST);
            cfg_pending <= 1'b0;
        end else begin
            if (cfg_we) shadow[cfg_addr] <= cfg_data;
            if (frame_start) begin
                cb_min <= shadow[0];
                cb_max <= shadow[1];
                cr_min <= shadow[2];
                cr_max <= shadow[3];
            end
            // A write coincident with frame_start misses that commit and stays pending.
            if (cfg_we)           cfg_pending <= 1'b1;
            else if (frame_start) cfg_pending <= 1'b0;
        end
    end

endmodule
